// File: rtl/counter_checker_if.sv
// Comparison bus feeding counter_checker: control plus expected/actual counter fields.
// The scoreboard/bench side drives through master; the checker samples through slave.
interface counter_checker_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             clear;
  logic [WIDTH-1:0] exp_Q;
  logic             exp_rco;
  logic             exp_load;
  logic [WIDTH-1:0] dut_Q;
  logic             dut_rco;
  logic             dut_load;

  modport master (
    output enable, clear,
    output exp_Q, exp_rco, exp_load,
    output dut_Q, dut_rco, dut_load
  );

  modport slave (
    input enable, clear,
    input exp_Q, exp_rco, exp_load,
    input dut_Q, dut_rco, dut_load
  );
endinterface

// File: rtl/counter_checker.sv
// Settle-windowed comparator of expected vs. actual counter outputs with saturating stats.
// Define CHECKER_FIRST_ERR_EN to keep a snapshot of the first mismatch (else those outputs read 0).
module counter_checker #(
  parameter int WIDTH  = 4,
  parameter int ERR_W  = 8,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               reset,
  counter_checker_if.slave   cmp,
  output logic               checking,
  output logic               mismatch,
  output logic               fail,
  output logic [ERR_W-1:0]   err_count,
  output logic [15:0]        check_count,
  output logic [WIDTH-1:0]   first_exp_Q,
  output logic [WIDTH-1:0]   first_dut_Q,
  output logic [15:0]        first_idx
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2
  } state_t;

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
  localparam logic [15:0]      CNT_MAX     = 16'hFFFF;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [3:0]         settle_cnt_r;
  logic [3:0]         settle_nxt_s;
  logic               do_cmp_s;
  logic               diff_s;
  logic               checking_r;
  logic               mismatch_r;
  logic               fail_r;
  logic [ERR_W-1:0]   err_count_r;
  logic [15:0]        check_count_r;

  function automatic logic fields_differ(
    input logic [WIDTH-1:0] e_q,
    input logic [WIDTH-1:0] d_q,
    input logic             e_rco,
    input logic             d_rco,
    input logic             e_load,
    input logic             d_load
  );
    return (e_q != d_q) || (e_rco != d_rco) || (e_load != d_load);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == CNT_MAX) ? val : val + 16'd1;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] val);
    return (val == ERR_MAX) ? val : val + {{(ERR_W-1){1'b0}}, 1'b1};
  endfunction

  assign diff_s = fields_differ(cmp.exp_Q, cmp.dut_Q, cmp.exp_rco, cmp.dut_rco,
                                cmp.exp_load, cmp.dut_load);

  // Next-state, settle countdown and compare-qualify decode.
  always_comb begin
    state_nxt_s  = state_r;
    settle_nxt_s = settle_cnt_r;
    do_cmp_s     = 1'b0;
    if (cmp.clear) begin
      // A clear restarts the settle window rather than comparing this cycle.
      state_nxt_s  = cmp.enable ? ST_SETTLE : ST_IDLE;
      settle_nxt_s = SETTLE_LOAD;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmp.enable) begin
            state_nxt_s  = ST_SETTLE;
            settle_nxt_s = SETTLE_LOAD;
          end else begin
            state_nxt_s  = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (!cmp.enable) begin
            state_nxt_s = ST_IDLE;
          end else if (settle_cnt_r <= 4'd1) begin
            // The decrement that lands on zero is the one that opens the compare window.
            state_nxt_s  = ST_CHECK;
            settle_nxt_s = 4'd0;
          end else begin
            settle_nxt_s = settle_cnt_r - 4'd1;
          end
        end
        ST_CHECK: begin
          if (cmp.enable) begin
            do_cmp_s    = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        default: begin
          state_nxt_s  = ST_IDLE;
          settle_nxt_s = 4'd0;
        end
      endcase
    end
  end

  // State register and settle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= 4'd0;
      checking_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      settle_cnt_r <= settle_nxt_s;
      checking_r   <= (state_nxt_s == ST_CHECK);
    end
  end

  // Per-compare statistics: pulse, sticky fail and saturating counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch_r    <= 1'b0;
      fail_r        <= 1'b0;
      err_count_r   <= {ERR_W{1'b0}};
      check_count_r <= 16'd0;
    end else if (cmp.clear) begin
      mismatch_r    <= 1'b0;
      fail_r        <= 1'b0;
      err_count_r   <= {ERR_W{1'b0}};
      check_count_r <= 16'd0;
    end else if (do_cmp_s) begin
      mismatch_r    <= diff_s;
      check_count_r <= sat_inc16(check_count_r);
      if (diff_s) begin
        fail_r      <= 1'b1;
        err_count_r <= sat_inc_err(err_count_r);
      end else begin
        fail_r      <= fail_r;
        err_count_r <= err_count_r;
      end
    end else begin
      mismatch_r    <= 1'b0;
      fail_r        <= fail_r;
      err_count_r   <= err_count_r;
      check_count_r <= check_count_r;
    end
  end

`ifdef CHECKER_FIRST_ERR_EN
  logic [WIDTH-1:0] first_exp_q_r;
  logic [WIDTH-1:0] first_dut_q_r;
  logic [15:0]      first_idx_r;

  // First-mismatch snapshot; fail_r still low marks the first one since reset/clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_exp_q_r <= {WIDTH{1'b0}};
      first_dut_q_r <= {WIDTH{1'b0}};
      first_idx_r   <= 16'd0;
    end else if (cmp.clear) begin
      first_exp_q_r <= {WIDTH{1'b0}};
      first_dut_q_r <= {WIDTH{1'b0}};
      first_idx_r   <= 16'd0;
    end else if (do_cmp_s && diff_s && !fail_r) begin
      first_exp_q_r <= cmp.exp_Q;
      first_dut_q_r <= cmp.dut_Q;
      first_idx_r   <= check_count_r;
    end else begin
      first_exp_q_r <= first_exp_q_r;
      first_dut_q_r <= first_dut_q_r;
      first_idx_r   <= first_idx_r;
    end
  end

  assign first_exp_Q = first_exp_q_r;
  assign first_dut_Q = first_dut_q_r;
  assign first_idx   = first_idx_r;
`else
  assign first_exp_Q = {WIDTH{1'b0}};
  assign first_dut_Q = {WIDTH{1'b0}};
  assign first_idx   = 16'd0;
`endif

  assign checking    = checking_r;
  assign mismatch    = mismatch_r;
  assign fail        = fail_r;
  assign err_count   = err_count_r;
  assign check_count = check_count_r;

endmodule

// File: tb/tb_counter_checker.sv
// Self-checking bench for counter_checker: vector table through a scoreboard queue,
// plus hand sequences for asynchronous reset and a 2-bit error counter saturating.
module tb_counter_checker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  counter_checker_if #(.WIDTH(4)) bus ();

  logic        chk0, mis0, fail0;
  logic [7:0]  err0;
  logic [15:0] cnt0, fidx0;
  logic [3:0]  feq0, fdq0;
  logic        chk1, mis1, fail1;
  logic [1:0]  err1;
  logic [15:0] cnt1, fidx1;
  logic [3:0]  feq1, fdq1;

  counter_checker #(.WIDTH(4), .ERR_W(8), .SETTLE(2)) u0 (
    .clk(clk), .reset(reset), .cmp(bus.slave),
    .checking(chk0), .mismatch(mis0), .fail(fail0), .err_count(err0),
    .check_count(cnt0), .first_exp_Q(feq0), .first_dut_Q(fdq0), .first_idx(fidx0)
  );

  counter_checker #(.WIDTH(4), .ERR_W(2), .SETTLE(2)) u1 (
    .clk(clk), .reset(reset), .cmp(bus.slave),
    .checking(chk1), .mismatch(mis1), .fail(fail1), .err_count(err1),
    .check_count(cnt1), .first_exp_Q(feq1), .first_dut_Q(fdq1), .first_idx(fidx1)
  );

`ifdef CHECKER_FIRST_ERR_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  typedef struct packed {
    logic        en;
    logic        clr;
    logic [3:0]  eq;
    logic        erco;
    logic        eload;
    logic [3:0]  dq;
    logic        drco;
    logic        dload;
    logic        x_chk;
    logic        x_mis;
    logic        x_fail;
    logic [7:0]  x_err;
    logic [15:0] x_cnt;
    logic [3:0]  x_feq;
    logic [3:0]  x_fdq;
    logic [15:0] x_fidx;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input int en, input int clr,
                              input int eq, input int erco, input int eload,
                              input int dq, input int drco, input int dload,
                              input int xc, input int xm, input int xf,
                              input int xe, input int xn,
                              input int xfe, input int xfd, input int xfi);
    vec_t v;
    v.en = 1'(en);      v.clr = 1'(clr);
    v.eq = 4'(eq);      v.erco = 1'(erco);   v.eload = 1'(eload);
    v.dq = 4'(dq);      v.drco = 1'(drco);   v.dload = 1'(dload);
    v.x_chk = 1'(xc);   v.x_mis = 1'(xm);    v.x_fail = 1'(xf);
    v.x_err = 8'(xe);   v.x_cnt = 16'(xn);
    v.x_feq = 4'(xfe);  v.x_fdq = 4'(xfd);   v.x_fidx = 16'(xfi);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.enable   = v.en;
    bus.clear    = v.clr;
    bus.exp_Q    = v.eq;
    bus.exp_rco  = v.erco;
    bus.exp_load = v.eload;
    bus.dut_Q    = v.dq;
    bus.dut_rco  = v.drco;
    bus.dut_load = v.dload;
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    sb_q.push_back(v);
    drive(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("checking",    32'(chk0),  32'(e.x_chk));
    chk("mismatch",    32'(mis0),  32'(e.x_mis));
    chk("fail",        32'(fail0), 32'(e.x_fail));
    chk("err_count",   32'(err0),  32'(e.x_err));
    chk("check_count", 32'(cnt0),  32'(e.x_cnt));
    chk("first_exp_Q", 32'(feq0),  32'(SNAP ? e.x_feq  : 4'd0));
    chk("first_dut_Q", 32'(fdq0),  32'(SNAP ? e.x_fdq  : 4'd0));
    chk("first_idx",   32'(fidx0), 32'(SNAP ? e.x_fidx : 16'd0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " checking"},    32'(chk0),  32'd0);
    chk({tag, " mismatch"},    32'(mis0),  32'd0);
    chk({tag, " fail"},        32'(fail0), 32'd0);
    chk({tag, " err_count"},   32'(err0),  32'd0);
    chk({tag, " check_count"}, 32'(cnt0),  32'd0);
    chk({tag, " snapshot"},    32'({feq0, fdq0, fidx0}), 32'd0);
    chk({tag, " u1 err"},      32'(err1),  32'd0);
    chk({tag, " u1 fail"},     32'(fail1), 32'd0);
    chk({tag, " u1 count"},    32'(cnt1),  32'd0);
  endtask

  initial begin
    // Order of fields: en clr | eQ erco eload | dQ drco dload | chk mis fail | err cnt | fexp fdut fidx
    vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0));
    for (int k = 1; k <= 20; k++) begin
      vecs.push_back(mk(1,0, k % 16,((k % 16) == 15) ? 1 : 0,0, k % 16,((k % 16) == 15) ? 1 : 0,0,
                        (k >= 2) ? 1 : 0,0,0, 0,(k >= 3) ? k - 2 : 0, 0,0,0));
    end
    vecs.push_back(mk(1,1, 2,0,0, 2,0,0, 0,0,0, 0,0, 0,0,0));
    vecs.push_back(mk(1,0, 2,0,0, 2,0,0, 1,0,0, 0,0, 0,0,0));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(1,0, i,0,0, i,0,0, 1,0,0, 0,i + 1, 0,0,0));
    end
    vecs.push_back(mk(1,0, 6,0,0, 7,0,0, 1,1,1, 1,6, 6,7,5));
    vecs.push_back(mk(1,0, 8,0,0, 8,0,0, 1,0,1, 1,7, 6,7,5));
    vecs.push_back(mk(1,1, 6,0,0, 7,0,0, 0,0,0, 0,0, 0,0,0));
    vecs.push_back(mk(1,0, 3,0,0, 3,0,0, 1,0,0, 0,0, 0,0,0));
    vecs.push_back(mk(1,0, 3,1,0, 3,0,0, 1,1,1, 1,1, 3,3,0));
    vecs.push_back(mk(1,0, 3,0,1, 3,0,0, 1,1,1, 2,2, 3,3,0));
    vecs.push_back(mk(1,0, 4,0,0, 4,0,0, 1,0,1, 2,3, 3,3,0));
    for (int i = 0; i < 3; i++) begin
      vecs.push_back(mk(0,0, 1,0,0, 2,0,0, 0,0,1, 2,3, 3,3,0));
    end
    vecs.push_back(mk(1,0, 1,0,0, 2,0,0, 0,0,1, 2,3, 3,3,0));
    vecs.push_back(mk(1,0, 1,0,0, 2,0,0, 1,0,1, 2,3, 3,3,0));
    vecs.push_back(mk(1,0, 5,0,0, 5,0,0, 1,0,1, 2,4, 3,3,0));
    vecs.push_back(mk(1,0, 9,0,0, 8,0,0, 1,1,1, 3,5, 3,3,0));

    reset = 1'b1;
    drive(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0));
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    #2 reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset between edges while in CHECK with err_count = 3.
    #3 reset = 1'b1;
    #1;
    chk_all_zero("async reset");
    @(posedge clk);
    #1;
    chk_all_zero("held reset");
    #2 reset = 1'b0;
    apply(mk(1,0, 5,0,0, 5,0,0, 0,0,0, 0,0, 0,0,0));
    apply(mk(1,0, 5,0,0, 5,0,0, 1,0,0, 0,0, 0,0,0));

    // Six back-to-back mismatches: u1 (2-bit err_count) saturates at 3.
    for (int k = 1; k <= 6; k++) begin
      apply(mk(1,0, 10,0,0, 5,0,0, 1,1,1, k,k, 10,5,0));
      chk("sat u1 err_count",   32'(err1),  32'((k < 3) ? k : 3));
      chk("sat u1 mismatch",    32'(mis1),  32'd1);
      chk("sat u1 fail",        32'(fail1), 32'd1);
      chk("sat u1 check_count", 32'(cnt1),  32'(k));
    end
    apply(mk(1,0, 5,0,0, 5,0,0, 1,0,1, 6,7, 10,5,0));
    chk("sat u1 mismatch end", 32'(mis1), 32'd0);
    chk("sat u1 err hold",     32'(err1), 32'd3);
    chk("sat u1 count end",    32'(cnt1), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
